// File: rtl/fxnum_expand_stream_if.sv
// Stream bundle for fxnum_expand_stream: narrow input samples, widened output
// samples with frame tag, and the per-frame headroom report.
interface fxnum_expand_stream_if #(
  parameter int NBITS_IN  = 6,
  parameter int NBITS_OUT = 8
);
  localparam int HW = $clog2(NBITS_IN);

  logic [NBITS_IN-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [NBITS_OUT-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [HW-1:0]        frame_headroom;
  logic                 headroom_valid;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_headroom, headroom_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_headroom, headroom_valid
  );
endinterface

// File: rtl/fxnum_expand_stream.sv
// Widening fixed-point stream converter with frame tagging and per-frame headroom.
// Headroom tracking is built only when FXEXP_HEADROOM_EN is defined.
module fxnum_expand_stream #(
  parameter int NBITS_IN  = 6,
  parameter int NBI_IN    = 1,
  parameter int NBF_IN    = 5,
  parameter int NBITS_OUT = 8,
  parameter int NBI_OUT   = 1,
  parameter int NBF_OUT   = 7,
  parameter int FRAME_LEN = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fxnum_expand_stream_if.slave  bus
);
  localparam int HW    = $clog2(NBITS_IN);
  localparam int CW    = $clog2(FRAME_LEN);
  localparam int SHIFT = NBF_OUT - NBF_IN;
  localparam int EXT_W = NBITS_IN + NBI_OUT - NBI_IN;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  logic                  in_fire_s;
  logic                  out_fire_s;
  logic signed [EXT_W-1:0] ext_s;
  logic [NBITS_OUT-1:0]  conv_s;
  logic [NBITS_OUT-1:0]  out_data_r;
  logic                  out_valid_r;
  logic                  out_last_r;
  logic [CW-1:0]         cnt_r;

  assign bus.in_ready  = !out_valid_r || bus.out_ready;
  assign in_fire_s     = bus.in_valid && bus.in_ready;
  assign out_fire_s    = out_valid_r && bus.out_ready;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;

  // Sign-extend the integer part, then shift left to zero-pad the fraction.
  always_comb begin
    ext_s  = EXT_W'($signed(bus.in_data));
    conv_s = NBITS_OUT'(ext_s) <<< SHIFT;
  end

  // Output register stage and frame position counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= {NBITS_OUT{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      cnt_r       <= {CW{1'b0}};
    end else if (in_fire_s) begin
      out_data_r  <= conv_s;
      out_valid_r <= 1'b1;
      out_last_r  <= (cnt_r == LAST_CNT);
      cnt_r       <= cnt_r + CW'(1);
    end else if (out_fire_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef FXEXP_HEADROOM_EN
  localparam logic [HW-1:0] HR_MAX = HW'(NBITS_IN - 1);

  logic [HW-1:0] samp_hr_r;
  logic [HW-1:0] acc_r;
  logic [HW-1:0] frame_hr_r;
  logic          hr_valid_r;
  logic [HW-1:0] min_s;

  // Redundant sign bits: run length below the sign bit of bits matching it.
  function automatic logic [HW-1:0] calc_headroom(input logic [NBITS_IN-1:0] d);
    logic [HW-1:0] cnt;
    logic          run;
    cnt = {HW{1'b0}};
    run = 1'b1;
    for (int i = NBITS_IN - 2; i >= 0; i--) begin
      if (run && (d[i] == d[NBITS_IN-1])) begin
        cnt = cnt + HW'(1);
      end else begin
        run = 1'b0;
      end
    end
    return cnt;
  endfunction

  assign min_s              = (samp_hr_r < acc_r) ? samp_hr_r : acc_r;
  assign bus.frame_headroom = frame_hr_r;
  assign bus.headroom_valid = hr_valid_r;

  // Headroom of the registered beat travels with it; the frame minimum is
  // folded in when that beat leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_hr_r  <= {HW{1'b0}};
      acc_r      <= HR_MAX;
      frame_hr_r <= {HW{1'b0}};
      hr_valid_r <= 1'b0;
    end else begin
      if (in_fire_s) begin
        samp_hr_r <= calc_headroom(bus.in_data);
      end else begin
        samp_hr_r <= samp_hr_r;
      end
      if (out_fire_s && out_last_r) begin
        frame_hr_r <= min_s;
        hr_valid_r <= 1'b1;
        acc_r      <= HR_MAX;
      end else if (out_fire_s) begin
        acc_r      <= min_s;
        hr_valid_r <= 1'b0;
      end else begin
        hr_valid_r <= 1'b0;
      end
    end
  end
`else
  assign bus.frame_headroom = {HW{1'b0}};
  assign bus.headroom_valid = 1'b0;
`endif

endmodule
